stopwatch_bcd_counter: RTL and testbench
========================================

STOPWATCH_BCD_COUNTER -- requirements
Module: stopwatch_bcd_counter

Interface
REQ-001 SHALL have parameter MAX_MIN, default 59, meaning the highest minutes value before wrap (legal 1..99).
REQ-002 SHALL have parameter OVF_STICKY, default 1; 1 = overflow held until clear, 0 = overflow is a one-cycle pulse.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tick_100hz  input  1  one-clk-wide 100 Hz enable pulse from the hundredth-seconds divider.
REQ-006 SHALL have port start_stop  input  1  debounced one-cycle pulse that toggles run/pause.
REQ-007 SHALL have port clear  input  1  debounced one-cycle pulse that zeroes the count.
REQ-008 SHALL have port cs_bcd  output  8  centiseconds as two BCD digits, 00-99.
REQ-009 SHALL have port sec_bcd  output  8  seconds as two BCD digits, 00-59.
REQ-010 SHALL have port min_bcd  output  8  minutes as two BCD digits, 00-MAX_MIN.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port overflow  output  1  wrap indicator per OVF_STICKY.

Function
REQ-013 SHALL implement FSM states IDLE (count zero), RUN, PAUSE.
REQ-014 Transitions SHALL be: IDLE-start_stop->RUN; RUN-start_stop->PAUSE; PAUSE-start_stop->RUN; any state-clear->IDLE.
REQ-015 Count SHALL advance by exactly one centisecond per tick_100hz sampled high while in RUN; outputs SHALL change on the clk edge after the tick (latency 1).
REQ-016 Centiseconds SHALL wrap 99->00 with carry to seconds; seconds 59->00 with carry to minutes; each digit SHALL stay within 0-9 at all times.
REQ-017 At MAX_MIN:59.99 plus a tick, count SHALL become 00:00.00, overflow SHALL assert on the same edge, and state SHALL stay RUN.
REQ-018 clear SHALL take priority over start_stop and tick_100hz in the same cycle: count 00:00.00, state IDLE, overflow 0, tick discarded.
REQ-019 A tick coincident with start_stop SHALL be evaluated against the state before the transition (counted when leaving RUN, not counted when entering RUN).
REQ-020 Ticks in IDLE or PAUSE SHALL leave the count unchanged.
REQ-021 running SHALL be a registered decode of state RUN.

Reset
REQ-022 On reset all outputs SHALL be 0 (00:00.00, running 0, overflow 0) and state IDLE, on the next clk edge.
REQ-023 reset asserted mid-count SHALL override every other input, including clear and tick_100hz.

Configuration
REQ-024 With macro STOPWATCH_LAP_EN defined, the block SHALL add input lap (1-bit pulse) and output lap_frozen (1); lap in RUN SHALL freeze the cs/sec/min outputs at the current value while the internal count continues; a second lap SHALL release them; clear or reset SHALL release them.
REQ-025 Without STOPWATCH_LAP_EN, the lap and lap_frozen ports and the freeze register SHALL NOT exist, and outputs SHALL always show the live count.

Structure
REQ-026 Package stopwatch_pkg SHALL hold the state enum (IDLE/RUN/PAUSE), the bcd_digit_t 4-bit typedef and the constants CS_MAX=99 and SEC_MAX=59.
REQ-027 A sub-module bcd_digit_counter (enable, configurable terminal digit, carry-out) SHALL be instantiated once per digit pair.

Verification
REQ-028 Reset, start_stop, 100 ticks -> 00:01.00, running=1.
REQ-029 Preload to 00:59.99 via ticks, 1 tick -> 01:00.00, no overflow.
REQ-030 MAX_MIN=1, run to 01:59.99, 1 tick -> 00:00.00, overflow=1 (held with OVF_STICKY=1; one cycle with 0), running=1.
REQ-031 RUN at 00:00.05, start_stop+tick same cycle -> 00:00.06, PAUSE; 10 more ticks -> still 00:00.06.
REQ-032 clear+start_stop+tick same cycle at 00:03.00 -> 00:00.00, IDLE, running=0.
REQ-033 STOPWATCH_LAP_EN: lap at 00:02.00, 50 ticks -> outputs 00:02.00, lap_frozen=1; lap -> outputs 00:02.50.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch BCD counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;

    // Converts a binary value 0..99 into a packed pair of BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input int unsigned v);
        return {bcd_digit_t'(v / 10), bcd_digit_t'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD counter with enable, a configurable terminal value and a
// carry-out that fires on the enabled step that wraps the pair back to 00.
module bcd_digit_counter #(
    parameter int MAX_VAL = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       en_i,
    output logic [7:0] bcd_o,
    output logic       carry_o
);
    import stopwatch_pkg::*;

    localparam logic [7:0] TERM = to_bcd(MAX_VAL);

    bcd_digit_t ones_q, ones_d;
    bcd_digit_t tens_q, tens_d;
    logic       at_term;

    assign at_term = ({tens_q, ones_q} == TERM);
    assign carry_o = en_i && at_term;
    assign bcd_o   = {tens_q, ones_q};

    // Next-digit logic: clear wins, otherwise step with decimal carry between digits.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ones_d = ones_q;
        tens_d = tens_q;
        if (clear_i) begin
            ones_d = '0;
            tens_d = '0;
        end else if (en_i) begin
            if (at_term) begin
                ones_d = '0;
                tens_d = '0;
            end else if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Digit registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch counting MM:SS.CC in BCD with run/pause/clear control and a
// wrap indicator. Optional lap-freeze feature enabled by STOPWATCH_LAP_EN.
module stopwatch_bcd_counter #(
    parameter int MAX_MIN    = 59,
    parameter int OVF_STICKY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_100hz,
    input  logic       start_stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
    output logic       lap_frozen,
`endif
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       overflow
);
    import stopwatch_pkg::*;

    sw_state_e  state_q, state_d;
    logic       running_q;
    logic       overflow_q, overflow_d;
    logic       count_en;
    logic       cs_carry, sec_carry, wrap;
    logic [7:0] cs_live, sec_live, min_live;

    // Ticks count against the state before any transition on this edge.
    assign count_en = tick_100hz && (state_q == RUN) && !clear;

    bcd_digit_counter #(.MAX_VAL(CS_MAX)) u_cs (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .en_i    (count_en),
        .bcd_o   (cs_live),
        .carry_o (cs_carry)
    );

    bcd_digit_counter #(.MAX_VAL(SEC_MAX)) u_sec (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .en_i    (cs_carry),
        .bcd_o   (sec_live),
        .carry_o (sec_carry)
    );

    bcd_digit_counter #(.MAX_VAL(MAX_MIN)) u_min (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .en_i    (sec_carry),
        .bcd_o   (min_live),
        .carry_o (wrap)
    );

    // Next-state and overflow logic; clear overrides start_stop.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        if (clear) begin
            state_d    = IDLE;
            overflow_d = 1'b0;
        end else begin
            if (start_stop) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end
            if (OVF_STICKY != 0) overflow_d = overflow_q || wrap;
            else                 overflow_d = wrap;
        end
    end

    // State, running decode and overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= (state_d == RUN);
            overflow_q <= overflow_d;
        end
    end

    assign running  = running_q;
    assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
    logic        frozen_q, frozen_d;
    logic [23:0] snap_q, snap_d;

    // Lap toggles the freeze while running; any lap releases; clear releases.
    always_comb begin
        frozen_d = frozen_q;
        snap_d   = snap_q;
        if (clear) begin
            frozen_d = 1'b0;
        end else if (lap) begin
            if (frozen_q) begin
                frozen_d = 1'b0;
            end else if (state_q == RUN) begin
                frozen_d = 1'b1;
                snap_d   = {min_live, sec_live, cs_live};
            end
        end
    end

    // Freeze flag and captured display value.
    always_ff @(posedge clk) begin
        if (reset) begin
            frozen_q <= 1'b0;
            snap_q   <= '0;
        end else begin
            frozen_q <= frozen_d;
            snap_q   <= snap_d;
        end
    end

    assign lap_frozen = frozen_q;
    assign min_bcd    = frozen_q ? snap_q[23:16] : min_live;
    assign sec_bcd    = frozen_q ? snap_q[15:8]  : sec_live;
    assign cs_bcd     = frozen_q ? snap_q[7:0]   : cs_live;
`else
    assign min_bcd = min_live;
    assign sec_bcd = sec_live;
    assign cs_bcd  = cs_live;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter: a table of directed vectors
// on the default configuration plus hand-written wrap, reset and lap sequences.
module tb_stopwatch_bcd_counter;

    logic clk = 1'b0;
    logic reset, tick_100hz, start_stop, clear;
    logic [7:0] cs0, s0, m0, cs1, s1, m1, cs2, s2, m2;
    logic run0, run1, run2, ovf0, ovf1, ovf2;
`ifdef STOPWATCH_LAP_EN
    logic lap;
    logic lf0, lf1, lf2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stopwatch_bcd_counter dut0 (
        .clk(clk), .reset(reset), .tick_100hz(tick_100hz), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .lap_frozen(lf0),
`endif
        .cs_bcd(cs0), .sec_bcd(s0), .min_bcd(m0), .running(run0), .overflow(ovf0)
    );

    stopwatch_bcd_counter #(.MAX_MIN(1), .OVF_STICKY(1)) dut1 (
        .clk(clk), .reset(reset), .tick_100hz(tick_100hz), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .lap_frozen(lf1),
`endif
        .cs_bcd(cs1), .sec_bcd(s1), .min_bcd(m1), .running(run1), .overflow(ovf1)
    );

    stopwatch_bcd_counter #(.MAX_MIN(1), .OVF_STICKY(0)) dut2 (
        .clk(clk), .reset(reset), .tick_100hz(tick_100hz), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap), .lap_frozen(lf2),
`endif
        .cs_bcd(cs2), .sec_bcd(s2), .min_bcd(m2), .running(run2), .overflow(ovf2)
    );

    typedef struct {
        string       name;
        logic        ss;
        logic        clr;
        logic        tick;
        int          reps;
        logic [23:0] exp_cnt;
        logic        exp_run;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic ss, input logic clr, input logic tick,
                       input int reps, input logic [23:0] cnt, input logic r, input logic o);
        vec_t v;
        v.name = n; v.ss = ss; v.clr = clr; v.tick = tick; v.reps = reps;
        v.exp_cnt = cnt; v.exp_run = r; v.exp_ovf = o;
        vecs.push_back(v);
    endtask

    // One clock: inputs already driven, advance past the edge, then drop pulses.
    task automatic step();
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        reset      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap        = 1'b0;
`endif
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick_100hz = 1'b1;
            step();
        end
        tick_100hz = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_100hz = 1'b0; start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif
        step();
        check("reset_count", {8'h0, m0, s0, cs0}, 32'h0);
        check("reset_running", {31'b0, run0}, 32'h0);
        check("reset_overflow", {31'b0, ovf0}, 32'h0);

        add("start",         1, 0, 0, 1,    24'h000000, 1, 0);
        add("ticks_100",     0, 0, 1, 100,  24'h000100, 1, 0);
        add("to_00_59_99",   0, 0, 1, 5899, 24'h005999, 1, 0);
        add("min_carry",     0, 0, 1, 1,    24'h010000, 1, 0);
        add("pause",         1, 0, 0, 1,    24'h010000, 0, 0);
        add("pause_ticks",   0, 0, 1, 10,   24'h010000, 0, 0);
        add("clear_paused",  0, 1, 0, 1,    24'h000000, 0, 0);
        add("restart",       1, 0, 0, 1,    24'h000000, 1, 0);
        add("run_5",         0, 0, 1, 5,    24'h000005, 1, 0);
        add("ss_tick_leave", 1, 0, 1, 1,    24'h000006, 0, 0);
        add("pause_10",      0, 0, 1, 10,   24'h000006, 0, 0);
        add("ss_tick_enter", 1, 0, 1, 1,    24'h000006, 1, 0);
        add("to_00_03_00",   0, 0, 1, 294,  24'h000300, 1, 0);
        add("clr_ss_tick",   1, 1, 1, 1,    24'h000000, 0, 0);
        add("idle_ticks",    0, 0, 1, 3,    24'h000000, 0, 0);
        add("ss_tick_idle",  1, 0, 1, 1,    24'h000000, 1, 0);
        add("tick_one",      0, 0, 1, 1,    24'h000001, 1, 0);
        add("to_00_00_11",   0, 0, 1, 10,   24'h000011, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                start_stop = (r == 0) ? vecs[i].ss  : 1'b0;
                clear      = (r == 0) ? vecs[i].clr : 1'b0;
                tick_100hz = vecs[i].tick;
                step();
            end
            tick_100hz = 1'b0;
            check({vecs[i].name, "_count"}, {8'h0, m0, s0, cs0}, {8'h0, vecs[i].exp_cnt});
            check({vecs[i].name, "_running"}, {31'b0, run0}, {31'b0, vecs[i].exp_run});
            check({vecs[i].name, "_overflow"}, {31'b0, ovf0}, {31'b0, vecs[i].exp_ovf});
        end

        // Reset mid-count overrides clear, start_stop and tick together.
        reset = 1'b1; clear = 1'b1; start_stop = 1'b1; tick_100hz = 1'b1;
        step();
        tick_100hz = 1'b0;
        check("midreset_count", {8'h0, m0, s0, cs0}, 32'h0);
        check("midreset_running", {31'b0, run0}, 32'h0);

        // Minute wrap with MAX_MIN = 1, sticky and pulsed overflow.
        start_stop = 1'b1;
        step();
        ticks(11999);
        check("w1_pre_count", {8'h0, m1, s1, cs1}, 32'h015999);
        check("w2_pre_count", {8'h0, m2, s2, cs2}, 32'h015999);
        check("w1_pre_ovf", {31'b0, ovf1}, 32'h0);
        ticks(1);
        check("w1_wrap_count", {8'h0, m1, s1, cs1}, 32'h0);
        check("w2_wrap_count", {8'h0, m2, s2, cs2}, 32'h0);
        check("w1_wrap_ovf", {31'b0, ovf1}, 32'h1);
        check("w2_wrap_ovf", {31'b0, ovf2}, 32'h1);
        check("w1_wrap_running", {31'b0, run1}, 32'h1);
        step();
        check("w1_ovf_held", {31'b0, ovf1}, 32'h1);
        check("w2_ovf_pulse_end", {31'b0, ovf2}, 32'h0);
        ticks(1);
        check("w1_after_count", {8'h0, m1, s1, cs1}, 32'h000001);
        check("w1_ovf_still", {31'b0, ovf1}, 32'h1);
        clear = 1'b1;
        step();
        check("w1_clear_ovf", {31'b0, ovf1}, 32'h0);
        check("w1_clear_count", {8'h0, m1, s1, cs1}, 32'h0);
        check("w1_clear_running", {31'b0, run1}, 32'h0);

`ifdef STOPWATCH_LAP_EN
        // Lap freezes the display while the count keeps going.
        reset = 1'b1;
        step();
        start_stop = 1'b1;
        step();
        ticks(200);
        check("lap_pre_count", {8'h0, m0, s0, cs0}, 32'h000200);
        lap = 1'b1;
        step();
        ticks(50);
        check("lap_frozen_count", {8'h0, m0, s0, cs0}, 32'h000200);
        check("lap_frozen_flag", {31'b0, lf0}, 32'h1);
        lap = 1'b1;
        step();
        check("lap_release_count", {8'h0, m0, s0, cs0}, 32'h000250);
        check("lap_release_flag", {31'b0, lf0}, 32'h0);
        lap = 1'b1;
        step();
        clear = 1'b1;
        step();
        check("lap_clear_flag", {31'b0, lf0}, 32'h0);
        check("lap_clear_count", {8'h0, m0, s0, cs0}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
